// File: rtl/divider_pkg.sv
// divider_pkg: shared defaults, result record and helpers for the
// pipelined divider output stage (divider_out_buf / divider_out_fifo).
package divider_pkg;

    localparam int DEF_M      = 4;
    localparam int DEF_SERIES = 5;
    localparam int DEF_DEPTH  = 4;
    localparam int DEF_LAT    = 5;

    // One finished division as it leaves the last cell.
    typedef struct packed {
        logic [DEF_SERIES-1:0] quotient;
        logic [DEF_M-1:0]      remainder;
        logic                  dz;
    } div_result_t;

    // Pointer width for a power-of-two FIFO of the given depth.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/divider_out_fifo.sv
// divider_out_fifo: result storage for the divider output stage.
// Ports: clk, rstn (async low), push/wdata in, pop in, rdata (head entry),
// count (occupancy), full, empty. A push while full is accepted only
// alongside a pop; a pop while empty is ignored. Storage is not reset.
module divider_out_fifo
    import divider_pkg::*;
#(
    parameter  int W     = DEF_SERIES + DEF_M + 1,
    parameter  int DEPTH = DEF_DEPTH,
    localparam int PW    = ptr_width(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/divider_out_buf.sv
// divider_out_buf: output stage after the last divider_cell. Queues results,
// hands them out on a valid/ready port, and issues credit so that every
// in-flight division is guaranteed a FIFO slot on arrival.
// Ports: clk, rstn (async low); issue in, credit_ok out; in_valid,
// in_merchant, in_remainder, in_dz in; out_valid, out_quotient,
// out_remainder, out_dz out, out_ready in; err (sticky) out.
// Macro DIV_OUT_STATS_EN adds stat_done / stat_dz pop counters.
module divider_out_buf
    import divider_pkg::*;
#(
    parameter int M      = DEF_M,
    parameter int SERIES = DEF_SERIES,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int LAT    = DEF_LAT
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              issue,
    output logic              credit_ok,
    input  logic              in_valid,
    input  logic [SERIES-1:0] in_merchant,
    input  logic [M-1:0]      in_remainder,
    input  logic              in_dz,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SERIES-1:0] out_quotient,
    output logic [M-1:0]      out_remainder,
    output logic              out_dz,
`ifdef DIV_OUT_STATS_EN
    output logic [7:0]        stat_done,
    output logic [7:0]        stat_dz,
`endif
    output logic              err
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = PW + 1;
    localparam int W  = SERIES + M + 1;

    if (LAT < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_cfg
        $error("divider_out_buf: LAT >= 1 and power-of-two DEPTH >= 2 needed");
    end

    logic [CW-1:0] count;
    logic [CW-1:0] inflight;
    logic [CW:0]   occupied;
    logic          full;
    logic          empty;
    logic          pop;
    logic [W-1:0]  rdata;
    logic          bad_issue;
    logic          bad_drop;
    logic          bad_orphan;

    divider_out_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (in_valid),
        .wdata ({in_merchant, in_remainder, in_dz}),
        .pop   (pop),
        .rdata (rdata),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign {out_quotient, out_remainder, out_dz} = rdata;
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;

    // Slots already promised: queued entries plus divisions still in cells.
    assign occupied  = {1'b0, count} + {1'b0, inflight};
    assign credit_ok = occupied < (CW + 1)'(DEPTH);

    assign bad_issue  = issue && !credit_ok;
    assign bad_drop   = in_valid && full && !pop;
    assign bad_orphan = in_valid && (inflight == '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            inflight <= '0;
            err      <= 1'b0;
        end else begin
            if (issue && !in_valid && inflight != '1) begin
                inflight <= inflight + CW'(1);
            end else if (in_valid && !issue && inflight != '0) begin
                inflight <= inflight - CW'(1);
            end
            if (bad_issue || bad_drop || bad_orphan) begin
                err <= 1'b1;
            end
        end
    end

`ifdef DIV_OUT_STATS_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stat_done <= '0;
            stat_dz   <= '0;
        end else if (pop) begin
            stat_done <= stat_done + 8'd1;
            if (out_dz) begin
                stat_dz <= stat_dz + 8'd1;
            end
        end
    end
`endif

endmodule

// File: doc/divider_out_buf.md
# divider_out_buf

Output stage that sits directly downstream of the last `divider_cell` in the pipelined divider. It captures each finished quotient/remainder pair as it leaves the final pipeline stage and queues it in a small FIFO. It presents results to the consumer through a valid/ready handshake. Because the cell pipeline cannot stall, the block also issues a credit signal back to the upstream issue logic, which guarantees that every in-flight division has a free slot on arrival.

## Interface
- `M`, 4, divisor/remainder width (matches cell `M`)
- `SERIES`, 5, quotient width (matches cell `SERIES`)
- `DEPTH`, 4, FIFO entries, power of two, ≥2
- `LAT`, 5, pipeline latency in cycles from issue to `in_valid` (equals number of cells)

Ports:
- `clk` in 1: single clock, rising edge
- `rstn` in 1: asynchronous, active-low reset
- `issue` in 1: upstream launched one division into cell stage 1 this cycle
- `credit_ok` out 1: upstream may assert `issue` this cycle
- `in_valid` in 1: final cell stage presents a result this cycle
- `in_merchant` in SERIES: quotient from final stage
- `in_remainder` in M: remainder from final stage
- `in_dz` in 1: divide-by-zero flag carried alongside the pipeline
- `out_valid` out 1: head entry available
- `out_ready` in 1: consumer accepts head
- `out_quotient` out SERIES: head quotient
- `out_remainder` out M: head remainder
- `out_dz` out 1: head divide-by-zero flag
- `err` out 1: sticky protocol error

## Operation
- FIFO state: `wr_ptr` and `rd_ptr` of log2(DEPTH) bits each, wrapping modulo DEPTH; `count` of log2(DEPTH)+1 bits.
- Push: `in_valid` writes {merchant, remainder, dz} at `wr_ptr`, then `wr_ptr` increments.
- Pop: `out_valid && out_ready` increments `rd_ptr`.
- `out_*` data is driven from the entry at `rd_ptr`. It is undefined when `out_valid` = 0, and the bench does not check it then.
- `out_valid = (count != 0)`.
- In-flight counter `inflight` (log2(DEPTH)+1 bits):
  - +1 on `issue`; −1 on `in_valid`; unchanged when both occur in the same cycle.
- `credit_ok = (count + inflight) < DEPTH`. This is combinational from registers only, so it does not depend on same-cycle `issue` or `out_ready`.
- Simultaneous push and pop:
  - Both take effect and `count` is unchanged.
  - When full, a push accompanied by a pop is accepted.
- Protocol errors. Each sets `err`, which stays set until reset:
  - `issue` while `credit_ok` = 0: the issue is still counted into `inflight` (saturating at 2^(w)−1).
  - `in_valid` while full with no pop: the write is dropped and pointers are unchanged.
  - `in_valid` while `inflight` = 0: the entry is still pushed if space exists; `inflight` stays 0.
- Divide-by-zero entries are stored unmodified. The cell naturally yields an all-ones quotient for these.

## Timing
- Reset values: `credit_ok`=1, `out_valid`=0, `err`=0; all pointers and counters 0.
  - FIFO data is not reset, so `out_quotient`/`out_remainder`/`out_dz` are don't-care while `out_valid`=0.
- Latency: a push at edge t gives `out_valid`=1 from t (visible in the cycle after the capturing edge). No bypass path.
- Throughput: one push and one pop per cycle sustained.
- `credit_ok` updates one cycle after the `issue`/`in_valid`/pop that changes it.
- Reset asserted mid-operation discards all queued and in-flight state immediately. Upstream cell registers reset on the same `rstn`.

## Configuration
- `DIV_OUT_STATS_EN`:
  - Defined: adds output `stat_done` (8 bits, increments on each pop, wraps 255→0) and `stat_dz` (8 bits, increments on each pop with `out_dz`=1, wraps). Both reset to 0.
  - Undefined: neither port nor counter exists. All other behaviour is identical.

## Structure
- Shared package `divider_pkg`: default `M`, `SERIES`, `LAT`, `DEPTH`; a packed result struct type {quotient, remainder, dz}; a function computing pointer width.
- One sub-module, `divider_out_fifo`: storage, pointers, count, full/empty. The top level owns the credit and inflight logic, the error flag and the stats counters.

## Test plan
1. Reset with `rstn`=0 then release → `credit_ok`=1, `out_valid`=0, `err`=0.
2. Issue four divisions back-to-back with `out_ready`=0; deliver `in_valid` LAT cycles later with quotients 5,6,7,8:
   - `credit_ok` drops to 0 after the 4th issue.
   - `out_valid`=1 and results pop in order 5,6,7,8 once `out_ready`=1.
   - `err` stays 0.
3. Full FIFO with push and pop in the same cycle → `count` stays 4, the new entry lands at the tail, `err`=0.
4. Full FIFO, `in_valid`=1, `out_ready`=0 → entry dropped, `err`=1 and stays 1 through later traffic until reset.
5. Entry carrying `in_dz`=1 with quotient 0x1F → `out_dz`=1, `out_quotient`=0x1F; with the macro defined, `stat_dz` increments to 1 on pop.
6. Assert `rstn`=0 with 3 entries queued and 1 in flight → next cycle `out_valid`=0, `credit_ok`=1, counters 0.
